// File: rtl/ahb_pkg.sv
// Shared AHB encodings and slave FSM states for the on-chip SRAM window.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } slave_state_e;

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB master<->slave signal bundle (clock and reset travel as plain ports).
interface ahb_sram_slave_if
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 8
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  htrans_e           HTRANS;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  modport slave  (input  HSEL, HADDR, HWRITE, HTRANS, HWDATA,
                  output HRDATA, HREADYOUT, HRESP);
  modport master (output HSEL, HADDR, HWRITE, HTRANS, HWDATA,
                  input  HRDATA, HREADYOUT, HRESP);
endinterface

// File: rtl/ahb_sram_mem.sv
// Byte-wide storage: synchronous write, asynchronous read, contents not reset.
module ahb_sram_mem #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave fronting an on-chip byte SRAM window with optional wait states
// and a two-cycle ERROR response for addresses outside the window.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int              ADDR_W      = 21,
  parameter int              DATA_W      = 8,
  parameter int              MEM_DEPTH   = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              WAIT_STATES = 0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_sram_slave_if.slave  bus
);

  localparam int OFF_W = $clog2(MEM_DEPTH);
  localparam logic [1:0] WS_M1 = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  slave_state_e      state, state_n;
  logic [1:0]        wcnt, wcnt_n;
  logic [OFF_W-1:0]  off_q;
  logic              write_q;
  logic              load_addr;
  logic              hready, hresp;
  logic              xfer_vld, in_range;
  logic [ADDR_W:0]   off_full;
  logic [DATA_W-1:0] mem_rdata;

  assign xfer_vld = bus.HSEL &&
                    (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);

  // One extra bit so an address below BASE_ADDR shows up as negative
  // instead of wrapping into the window.
  assign off_full = {1'b0, bus.HADDR} - {1'b0, BASE_ADDR};
  assign in_range = !off_full[ADDR_W] && (off_full < (ADDR_W+1)'(MEM_DEPTH));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      off_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      if (load_addr) begin
        off_q   <= off_full[OFF_W-1:0];
        write_q <= bus.HWRITE;
      end
    end
  end

  always_comb begin
    state_n   = state;
    wcnt_n    = wcnt;
    hready    = 1'b1;
    hresp     = HRESP_OKAY;
    load_addr = 1'b0;
    unique case (state)
      S_WAIT: begin
        hready = 1'b0;
        if (wcnt == 2'd0) state_n = S_DATA;
        else              wcnt_n  = wcnt - 2'd1;
      end
      S_ERR1: begin
        hready  = 1'b0;
        hresp   = HRESP_ERROR;
        state_n = S_ERR2;
      end
      default: begin
        // S_IDLE, S_DATA and S_ERR2 all close with HREADYOUT high, so the
        // next address phase is sampled here.
        if (state == S_ERR2) hresp = HRESP_ERROR;
        state_n = S_IDLE;
        if (xfer_vld) begin
          if (in_range) begin
            load_addr = 1'b1;
            wcnt_n    = WS_M1;
            state_n   = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
          end else begin
            state_n = S_ERR1;
          end
        end
      end
    endcase
  end

  ahb_sram_mem #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk   (HCLK),
    .we    (state == S_DATA && write_q),
    .waddr (off_q),
    .wdata (bus.HWDATA),
    .raddr (off_q),
    .rdata (mem_rdata)
  );

  assign bus.HREADYOUT = hready;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = (state == S_DATA && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomized check of three slave instances (0, 2 and 3 wait states)
// against a per-instance byte-array model of the memory window.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam int WS_TAB [3] = '{0, 2, 3};

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  int          cur = 0;
  logic        hsel = 1'b0;
  logic [20:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [7:0]  hwdata = '0;

  logic [7:0]  rd [3];
  logic [2:0]  rdy, rsp;

  logic [7:0]  mdl [3][256];
  int          n_tot = 0;
  int          n_bad = 0;

  for (genvar k = 0; k < 3; k++) begin : g
    ahb_sram_slave_if #(.ADDR_W(21), .DATA_W(8)) bus ();
    assign bus.HSEL   = hsel && (cur == k);
    assign bus.HADDR  = haddr;
    assign bus.HWRITE = hwrite;
    assign bus.HTRANS = htrans_e'(htrans);
    assign bus.HWDATA = hwdata;
    assign rd[k]  = bus.HRDATA;
    assign rdy[k] = bus.HREADYOUT;
    assign rsp[k] = bus.HRESP;

    ahb_sram_slave #(
      .ADDR_W      (21),
      .DATA_W      (8),
      .MEM_DEPTH   (256),
      .BASE_ADDR   (21'h00000),
      .WAIT_STATES (WS_TAB[k])
    ) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // One transfer with an idle address phase behind it; checks every
  // data-phase cycle against what the window rules predict.
  task automatic xfer(input int k, input logic hs, input logic [1:0] tr,
                      input logic wr, input logic [20:0] a, input logic [7:0] wd);
    logic vld, inr;
    cur = k; hsel = hs; htrans = tr; hwrite = wr; haddr = a;
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    vld = hs && tr[1];
    inr = (a < 21'd256);
    if (!vld) begin
      chk("idle_rdy", 32'(rdy[k]), 1);
      chk("idle_rsp", 32'(rsp[k]), 0);
      chk("idle_rd",  32'(rd[k]),  0);
    end else if (!inr) begin
      chk("err1_rdy", 32'(rdy[k]), 0);
      chk("err1_rsp", 32'(rsp[k]), 1);
      chk("err1_rd",  32'(rd[k]),  0);
      tick();
      chk("err2_rdy", 32'(rdy[k]), 1);
      chk("err2_rsp", 32'(rsp[k]), 1);
    end else begin
      for (int i = 0; i < WS_TAB[k]; i++) begin
        chk("wait_rdy", 32'(rdy[k]), 0);
        chk("wait_rsp", 32'(rsp[k]), 0);
        tick();
      end
      chk("data_rdy", 32'(rdy[k]), 1);
      chk("data_rsp", 32'(rsp[k]), 0);
      chk("data_rd",  32'(rd[k]),  wr ? 32'd0 : 32'(mdl[k][a[7:0]]));
      if (wr) mdl[k][a[7:0]] = wd;
    end
    tick();
  endtask

  initial begin
    logic [20:0] a;
    int r;

    // reset held for three cycles
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        chk("rst_rdy", 32'(rdy[k]), 1);
        chk("rst_rsp", 32'(rsp[k]), 0);
        chk("rst_rd",  32'(rd[k]),  0);
      end
    end
    HRESETn = 1'b1;
    tick();
    chk("post_rst_rdy", 32'(rdy), 32'h7);

    // preload the low 64 bytes of every instance
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 64; i++)
        xfer(k, 1'b1, 2'b10, 1'b1, 21'(i), 8'($urandom));

    // back-to-back write then read, zero wait states
    cur = 0; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 21'h00010;
    tick();
    hwdata = 8'hA5; hwrite = 1'b0;
    chk("b2b_wr_rdy", 32'(rdy[0]), 1);
    chk("b2b_wr_rsp", 32'(rsp[0]), 0);
    mdl[0][16] = 8'hA5;
    tick();
    hsel = 1'b0; htrans = 2'b00;
    chk("b2b_rd_data", 32'(rd[0]), 32'hA5);
    chk("b2b_rd_rdy", 32'(rdy[0]), 1);
    chk("b2b_rd_rsp", 32'(rsp[0]), 0);
    tick();

    // two wait states
    xfer(1, 1'b1, 2'b10, 1'b1, 21'h00010, 8'hA5);
    xfer(1, 1'b1, 2'b10, 1'b0, 21'h00010, 8'h00);
    xfer(1, 1'b1, 2'b11, 1'b1, 21'h00011, 8'h3C);
    xfer(1, 1'b1, 2'b10, 1'b0, 21'h00011, 8'h00);

    // out of range write must not corrupt byte 0
    xfer(0, 1'b1, 2'b10, 1'b1, 21'h00100, 8'h77);
    xfer(0, 1'b1, 2'b10, 1'b0, 21'h00000, 8'h00);

    // non-transfers leave memory alone
    xfer(0, 1'b1, 2'b00, 1'b1, 21'h00010, 8'hFF);
    xfer(0, 1'b1, 2'b01, 1'b1, 21'h00010, 8'hFE);
    xfer(0, 1'b0, 2'b10, 1'b1, 21'h00010, 8'hFD);
    xfer(0, 1'b1, 2'b10, 1'b0, 21'h00010, 8'h00);

    // reset in the middle of a wait-stated write
    xfer(2, 1'b1, 2'b10, 1'b1, 21'h00020, 8'h11);
    cur = 2; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 21'h00020;
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = 8'hEE;
    chk("abort_wait_rdy", 32'(rdy[2]), 0);
    #2 HRESETn = 1'b0;
    #1;
    chk("abort_rdy", 32'(rdy[2]), 1);
    chk("abort_rsp", 32'(rsp[2]), 0);
    chk("abort_rd",  32'(rd[2]),  0);
    tick();
    tick();
    HRESETn = 1'b1;
    tick();
    chk("abort_no_err", 32'(rsp[2]), 0);
    xfer(2, 1'b1, 2'b10, 1'b0, 21'h00020, 8'h00);

    // random mix across all three instances
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = 21'($urandom_range(0, 63));
      else if (r == 8) a = 21'(256 + $urandom_range(0, 999));
      else             a = 21'h1FFF00 | 21'($urandom_range(0, 255));
      xfer($urandom_range(0, 2), ($urandom_range(0, 7) != 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    // final sweep: every preloaded byte of every instance
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 64; i++)
        xfer(k, 1'b1, 2'b10, 1'b0, 21'(i), 8'h00);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
